// File: rtl/result_commit_pipe.sv
// -----------------------------------------------------------------------------
// result_commit_pipe
//
// Producer side of the operand forwarding network. Results from the
// single-cycle ALU and from the long-latency unit (MUL/DIV) are merged into a
// commit register, which feeds a writeback register. Both stages drive
// operand/destination pairs for bypassing. The writeback stage also drives the
// register file write port.
//
// The ALU always wins the commit slot. Long-latency results wait in a small
// FIFO. That FIFO is drained only in cycles where the ALU is idle. stall_o asks
// the front end to leave an ALU-idle cycle so the FIFO can drain.
//
// Optional feature (compile-time macro RESULT_PIPE_STARVE_GUARD_EN):
//   defined   - a starve counter counts ALU wins over a non-empty FIFO.
//               stall_o = full | (counter == STARVE_LIMIT).
//   undefined - no counter; stall_o = full only.
//
// Parameters
//   FIFO_DEPTH    long-latency FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  ALU wins over a non-empty FIFO before stall_o (guard only)
//   XLEN          data width, fixed at 32 (not overridable)
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 synchronous reset, active-high
//   alu_valid_i           ALU result present (always accepted)
//   alu_result_i          ALU result
//   alu_reg_dest_i        ALU destination register
//   lu_valid_i            long-latency result offered
//   lu_result_i           long-latency result
//   lu_reg_dest_i         long-latency destination register
//   lu_ready_o            FIFO not full; transfer on lu_valid_i & lu_ready_o
//   stall_o               upstream must hold alu_valid_i low next cycle
//   commit_operand_o      commit stage operand (0 if invalid or dest x0)
//   commit_reg_dest_o     commit stage destination (0 if invalid)
//   writeback_operand_o   writeback stage operand (0 if invalid or dest x0)
//   writeback_reg_dest_o  writeback stage destination (0 if invalid)
//   rf_write_o            register file write enable
//   rf_addr_o             register file write address
//   rf_data_o             register file write data
// -----------------------------------------------------------------------------
module result_commit_pipe #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [4:0]      alu_reg_dest_i,
  input  logic            lu_valid_i,
  input  logic [XLEN-1:0] lu_result_i,
  input  logic [4:0]      lu_reg_dest_i,
  output logic            lu_ready_o,
  output logic            stall_o,
  output logic [XLEN-1:0] commit_operand_o,
  output logic [4:0]      commit_reg_dest_o,
  output logic [XLEN-1:0] writeback_operand_o,
  output logic [4:0]      writeback_reg_dest_o,
  output logic            rf_write_o,
  output logic [4:0]      rf_addr_o,
  output logic [XLEN-1:0] rf_data_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = XLEN + 5;

  // Elaboration-time parameter sanity.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("result_commit_pipe: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("result_commit_pipe: STARVE_LIMIT must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Long-latency FIFO state
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  head_data;
  logic [4:0]       head_dest;

  // ---------------------------------------------------------------------------
  // Pipeline stage state: p0 = commit, p1 = writeback
  // ---------------------------------------------------------------------------
  logic            vld_p0_q, vld_p0_d;
  logic [XLEN-1:0] data_p0_q, data_p0_d;
  logic [4:0]      dest_p0_q, dest_p0_d;
  logic            vld_p1_q, vld_p1_d;
  logic [XLEN-1:0] data_p1_q, data_p1_d;
  logic [4:0]      dest_p1_q, dest_p1_d;

  // FIFO status and handshake. Pops only happen when the ALU leaves the
  // commit slot free; a full FIFO refuses pushes even in a pop cycle, which
  // keeps lu_ready_o a pure function of registered state.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    push       = lu_valid_i & ~fifo_full;
    pop        = ~alu_valid_i & ~fifo_empty;
    head_dest  = fifo_mem_q[rd_ptr_q][ENT_W-1 -: 5];
    head_data  = fifo_mem_q[rd_ptr_q][XLEN-1:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Commit selection: ALU first, then FIFO head, else bubble. The writeback
  // stage copies the commit stage every cycle; nothing here ever stalls.
  always_comb begin
    vld_p0_d  = alu_valid_i | ~fifo_empty;
    data_p0_d = head_data;
    dest_p0_d = head_dest;
    if (alu_valid_i) begin
      data_p0_d = alu_result_i;
      dest_p0_d = alu_reg_dest_i;
    end
    vld_p1_d  = vld_p0_q;
    data_p1_d = data_p0_q;
    dest_p1_d = dest_p0_q;
  end

  // ---------------------------------------------------------------------------
  // Stage p0 / p1 boundary: control flops (reset) and data flops (no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Data registers carry no reset: every consumer is qualified by a valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {lu_reg_dest_i, lu_result_i};
    end
    data_p0_q <= data_p0_d;
    dest_p0_q <= dest_p0_d;
    data_p1_q <= data_p1_d;
    dest_p1_q <= dest_p1_d;
  end

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef RESULT_PIPE_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0] starve_q, starve_d;
  logic             starved;

  // Count ALU wins that left a waiting FIFO entry behind. Any drain, or an
  // empty FIFO, means nobody is starving.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_valid_i && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
    starved = (starve_q == STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    lu_ready_o = ~fifo_full;
    stall_o    = fifo_full | starved;
  end
`else
  always_comb begin
    lu_ready_o = ~fifo_full;
    stall_o    = fifo_full;
  end
`endif

  // ---------------------------------------------------------------------------
  // Forwarding and register file outputs
  // ---------------------------------------------------------------------------
  // An invalid stage or an x0 destination presents as (0, x0), so a consumer
  // that matches on x0 picks up a harmless zero.
  always_comb begin
    commit_operand_o     = '0;
    commit_reg_dest_o    = '0;
    writeback_operand_o  = '0;
    writeback_reg_dest_o = '0;
    if (vld_p0_q) begin
      commit_reg_dest_o = dest_p0_q;
      if (dest_p0_q != 5'd0) begin
        commit_operand_o = data_p0_q;
      end
    end
    if (vld_p1_q) begin
      writeback_reg_dest_o = dest_p1_q;
      if (dest_p1_q != 5'd0) begin
        writeback_operand_o = data_p1_q;
      end
    end
    rf_write_o = vld_p1_q & (dest_p1_q != 5'd0);
    rf_addr_o  = writeback_reg_dest_o;
    rf_data_o  = writeback_operand_o;
  end

`ifndef SYNTHESIS
  // The ALU still takes the slot if it ignores stall_o; flag it in simulation.
  stall_protocol_a : assert property (
    @(posedge clk_i) disable iff (rst_i) stall_o |=> !alu_valid_i
  ) else $error("result_commit_pipe: alu_valid_i asserted after stall_o");
`endif

endmodule

// File: tb/tb_result_commit_pipe.sv
// -----------------------------------------------------------------------------
// Directed testbench for result_commit_pipe (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the state loaded at that edge.
// -----------------------------------------------------------------------------
module tb_result_commit_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [31:0] alu_result_i;
  logic [4:0]  alu_reg_dest_i;
  logic        lu_valid_i;
  logic [31:0] lu_result_i;
  logic [4:0]  lu_reg_dest_i;
  logic        lu_ready_o;
  logic        stall_o;
  logic [31:0] commit_operand_o;
  logic [4:0]  commit_reg_dest_o;
  logic [31:0] writeback_operand_o;
  logic [4:0]  writeback_reg_dest_o;
  logic        rf_write_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;

  int checks   = 0;
  int failures = 0;

  result_commit_pipe dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .alu_valid_i          (alu_valid_i),
    .alu_result_i         (alu_result_i),
    .alu_reg_dest_i       (alu_reg_dest_i),
    .lu_valid_i           (lu_valid_i),
    .lu_result_i          (lu_result_i),
    .lu_reg_dest_i        (lu_reg_dest_i),
    .lu_ready_o           (lu_ready_o),
    .stall_o              (stall_o),
    .commit_operand_o     (commit_operand_o),
    .commit_reg_dest_o    (commit_reg_dest_o),
    .writeback_operand_o  (writeback_operand_o),
    .writeback_reg_dest_o (writeback_reg_dest_o),
    .rf_write_o           (rf_write_o),
    .rf_addr_o            (rf_addr_o),
    .rf_data_o            (rf_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alu(input logic v, input logic [31:0] d, input logic [4:0] r);
    alu_valid_i    = v;
    alu_result_i   = d;
    alu_reg_dest_i = r;
  endtask

  task automatic lu(input logic v, input logic [31:0] d, input logic [4:0] r);
    lu_valid_i    = v;
    lu_result_i   = d;
    lu_reg_dest_i = r;
  endtask

  task automatic chk_commit(input string tag, input logic [31:0] d, input logic [4:0] r);
    chk({tag, "_cop"}, commit_operand_o, d);
    chk({tag, "_cdst"}, {27'd0, commit_reg_dest_o}, {27'd0, r});
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] d, input logic [4:0] r,
                        input logic we);
    chk({tag, "_wop"}, writeback_operand_o, d);
    chk({tag, "_wdst"}, {27'd0, writeback_reg_dest_o}, {27'd0, r});
    chk({tag, "_rfwe"}, {31'd0, rf_write_o}, {31'd0, we});
    chk({tag, "_rfad"}, {27'd0, rf_addr_o}, {27'd0, r});
    chk({tag, "_rfdt"}, rf_data_o, d);
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic stl);
    chk({tag, "_rdy"}, {31'd0, lu_ready_o}, {31'd0, rdy});
    chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, stl});
  endtask

`ifdef RESULT_PIPE_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  initial begin
    rst_i = 1'b1;
    alu(1'b0, 32'd0, 5'd0);
    lu(1'b0, 32'd0, 5'd0);
    tick();
    tick();

    // Reset state
    chk_commit("rst", 32'd0, 5'd0);
    chk_wb("rst", 32'd0, 5'd0, 1'b0);
    chk_flags("rst", 1'b1, 1'b0);
    rst_i = 1'b0;
    tick();

    // ALU result to commit, then writeback
    alu(1'b1, 32'hDEAD_BEEF, 5'd5);
    tick();
    chk_commit("alu_c", 32'hDEAD_BEEF, 5'd5);
    chk("alu_c_rfwe", {31'd0, rf_write_o}, 32'd0);
    alu(1'b0, 32'd0, 5'd0);
    tick();
    chk_wb("alu_w", 32'hDEAD_BEEF, 5'd5, 1'b1);
    chk_commit("alu_w", 32'd0, 5'd0);

    // ALU result to x0 is masked everywhere
    alu(1'b1, 32'h0000_1234, 5'd0);
    tick();
    chk_commit("x0_c", 32'd0, 5'd0);
    alu(1'b0, 32'd0, 5'd0);
    tick();
    chk_wb("x0_w", 32'd0, 5'd0, 1'b0);
    tick();

    // Two long-latency results, ALU idle: no fall-through, strict order
    lu(1'b1, 32'hAAAA_0003, 5'd3);
    tick();
    chk("ll_nofall", commit_operand_o, 32'd0);
    chk_flags("ll_a", 1'b1, 1'b0);
    lu(1'b1, 32'hBBBB_0004, 5'd4);
    tick();
    chk_commit("ll_a", 32'hAAAA_0003, 5'd3);
    chk_flags("ll_b", 1'b1, 1'b0);
    lu(1'b0, 32'd0, 5'd0);
    tick();
    chk_commit("ll_b", 32'hBBBB_0004, 5'd4);
    chk_wb("ll_a", 32'hAAAA_0003, 5'd3, 1'b1);
    tick();
    chk_commit("ll_empty", 32'd0, 5'd0);
    chk_wb("ll_b", 32'hBBBB_0004, 5'd4, 1'b1);

    // Continuous ALU while four long-latency results fill the FIFO
    for (int i = 0; i < 4; i++) begin
      alu(1'b1, 32'h0000_0100 + i, 5'd20);
      lu(1'b1, 32'hC000_0000 + i, 5'(10 + i));
      tick();
      chk("fill_rdy", {31'd0, lu_ready_o}, (i < 3) ? 32'd1 : 32'd0);
    end
    chk_commit("fill", 32'h0000_0103, 5'd20);
    chk("fill_stall", {31'd0, stall_o}, 32'd1);
    alu(1'b0, 32'd0, 5'd0);
    lu(1'b0, 32'd0, 5'd0);
    tick();
    chk_commit("pop0", 32'hC000_0000, 5'd10);
    chk_flags("pop0", 1'b1, 1'b0);
    tick();
    chk_commit("pop1", 32'hC000_0001, 5'd11);
    tick();
    chk_commit("pop2", 32'hC000_0002, 5'd12);
    tick();
    chk_commit("pop3", 32'hC000_0003, 5'd13);
    tick();
    chk_commit("drained", 32'd0, 5'd0);

    // One FIFO entry held back by continuous ALU traffic
    alu(1'b1, 32'h0000_0200, 5'd21);
    lu(1'b1, 32'hD000_0007, 5'd7);
    tick();
    lu(1'b0, 32'd0, 5'd0);
    chk_flags("stv0", 1'b1, 1'b0);
    tick();
    chk_flags("stv1", 1'b1, 1'b0);
    tick();
    chk_flags("stv2", 1'b1, 1'b0);
    tick();
    chk_flags("stv3", 1'b1, GUARD);
    chk_commit("stv3", 32'h0000_0200, 5'd21);
    alu(1'b0, 32'd0, 5'd0);
    tick();
    chk_commit("stv_pop", 32'hD000_0007, 5'd7);
    chk_flags("stv_pop", 1'b1, 1'b0);
    tick();
    chk_commit("stv_empty", 32'd0, 5'd0);

    // Reset mid-operation with two buffered entries and both stages valid
    alu(1'b1, 32'hE100_0001, 5'd22);
    lu(1'b1, 32'hE000_0008, 5'd8);
    tick();
    alu(1'b1, 32'hE100_0002, 5'd23);
    lu(1'b1, 32'hE000_0009, 5'd9);
    tick();
    chk_commit("pre_rst", 32'hE100_0002, 5'd23);
    chk_wb("pre_rst", 32'hE100_0001, 5'd22, 1'b1);
    rst_i = 1'b1;
    alu(1'b0, 32'd0, 5'd0);
    lu(1'b1, 32'hF000_000B, 5'd11);
    tick();
    chk_commit("mid_rst", 32'd0, 5'd0);
    chk_wb("mid_rst", 32'd0, 5'd0, 1'b0);
    chk_flags("mid_rst", 1'b1, 1'b0);
    rst_i = 1'b0;
    lu(1'b0, 32'd0, 5'd0);
    tick();
    chk_commit("post_rst", 32'd0, 5'd0);
    chk_wb("post_rst", 32'd0, 5'd0, 1'b0);
    tick();
    chk_commit("post_rst2", 32'd0, 5'd0);
    chk("post_rst2_rfwe", {31'd0, rf_write_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
